// File: rtl/jtag_xfer_ctrl.sv
// DP/AP transfer sequencer in front of the JTAG pin engine: caches the selected IR,
// retries WAIT, flushes posted AP reads through RDBUFF and sequences TAP abort.
module jtag_xfer_ctrl #(
  parameter int unsigned RETRY_MAX   = 16,
  parameter logic [1:0]  RDBUFF_ADDR = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_abort,
  input  logic        req_rnw,
  input  logic        req_apndp,
  input  logic [1:0]  req_addr32,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [2:0]  resp_ack,
  output logic [31:0] resp_rdata,
  output logic [1:0]  jtag_cmd,
  output logic [1:0]  jtag_addr32,
  output logic        jtag_rnw,
  output logic        jtag_apndp,
  output logic [31:0] jtag_dwrite,
  output logic        jtag_go,
  input  logic        jtag_idle,
  input  logic [2:0]  jtag_ack,
  input  logic [31:0] jtag_dread
);

  localparam int unsigned RW = $clog2(RETRY_MAX + 2);

  localparam logic [1:0] CMD_IR    = 2'd0;
  localparam logic [1:0] CMD_TFR   = 2'd1;
  localparam logic [1:0] CMD_ABORT = 2'd2;

  localparam logic [2:0] E_OK    = 3'b010;
  localparam logic [2:0] E_WAIT  = 3'b001;
  localparam logic [2:0] E_FAULT = 3'b100;

  localparam logic [2:0] ACK_OK   = 3'b001;
  localparam logic [2:0] ACK_WAIT = 3'b010;
  localparam logic [2:0] ACK_PERR = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_EVAL, S_RESP} state_t;
  typedef enum logic [1:0] {K_SETIR, K_XFER, K_RDBUFF, K_ABORT} kind_t;
  typedef enum logic [1:0] {IR_DP, IR_AP, IR_UNK} ir_t;

  state_t        state, state_d;
  kind_t         kind, kind_d;
  ir_t           ir, ir_d;
  logic [RW-1:0] retry, retry_d;

  logic        lat_rnw, lat_apndp;
  logic [1:0]  lat_addr32;
  logic [31:0] lat_wdata;

  logic        accept, launch, respond;
  logic [2:0]  ack_d;
  logic [31:0] rdata_d;
  logic [1:0]  go_cmd, go_addr32;
  logic        go_rnw, go_apndp;
  logic [31:0] go_dwrite;

  assign resp_valid = (state == S_RESP);

  always_comb begin
    state_d = state;
    kind_d  = kind;
    ir_d    = ir;
    retry_d = retry;
    accept  = 1'b0;
    launch  = 1'b0;
    respond = 1'b0;
    ack_d   = resp_ack;
    rdata_d = resp_rdata;
    unique case (state)
      S_IDLE: begin
        if (req_ready) begin
          if (req_abort) begin
            kind_d = K_ABORT;
            launch = 1'b1;
          end else if (req_valid) begin
            accept  = 1'b1;
            retry_d = '0;
            kind_d  = (ir == (req_apndp ? IR_AP : IR_DP)) ? K_XFER : K_SETIR;
            launch  = 1'b1;
          end
        end
      end
      S_LAUNCH: if (!jtag_idle) state_d = S_BUSY;
      S_BUSY:   if (jtag_idle)  state_d = S_EVAL;
      S_EVAL: begin
        unique case (kind)
          K_SETIR: begin
            // An IR that differs from the request's port can only be the DPACC switch for RDBUFF
            ir_d   = jtag_apndp ? IR_AP : IR_DP;
            kind_d = (jtag_apndp == lat_apndp) ? K_XFER : K_RDBUFF;
            launch = 1'b1;
          end
          K_ABORT: begin
            ir_d    = IR_UNK;
            retry_d = '0;
            respond = 1'b1;
            ack_d   = ACK_OK;
            rdata_d = '0;
          end
          default: begin
            if (jtag_ack == E_WAIT) begin
              if (retry < RW'(RETRY_MAX)) begin
                retry_d = retry + RW'(1);
                launch  = 1'b1;
              end else begin
                respond = 1'b1;
                ack_d   = ACK_WAIT;
                rdata_d = '0;
              end
            end else if (jtag_ack == E_OK) begin
              retry_d = '0;
              if (kind == K_XFER && lat_rnw && lat_apndp) begin
                kind_d = K_SETIR;
                launch = 1'b1;
              end else begin
                respond = 1'b1;
                ack_d   = ACK_OK;
                rdata_d = lat_rnw ? jtag_dread : '0;
              end
            end else if (jtag_ack == E_FAULT) begin
              respond = 1'b1;
              ack_d   = E_FAULT;
              rdata_d = '0;
            end else begin
              respond = 1'b1;
              ack_d   = ACK_PERR;
              rdata_d = '0;
              ir_d    = IR_UNK;
            end
          end
        endcase
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (launch)  state_d = S_LAUNCH;
    if (respond) state_d = S_RESP;
  end

  always_comb begin
    go_cmd    = CMD_IR;
    go_apndp  = 1'b0;
    go_rnw    = 1'b0;
    go_addr32 = '0;
    go_dwrite = '0;
    unique case (kind_d)
      K_SETIR:  go_apndp = accept ? req_apndp : 1'b0;
      K_XFER: begin
        go_cmd    = CMD_TFR;
        go_apndp  = accept ? req_apndp  : lat_apndp;
        go_rnw    = accept ? req_rnw    : lat_rnw;
        go_addr32 = accept ? req_addr32 : lat_addr32;
        go_dwrite = accept ? req_wdata  : lat_wdata;
      end
      K_RDBUFF: begin
        go_cmd    = CMD_TFR;
        go_rnw    = 1'b1;
        go_addr32 = RDBUFF_ADDR;
      end
      default:  go_cmd = CMD_ABORT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      kind        <= K_XFER;
      ir          <= IR_UNK;
      retry       <= '0;
      req_ready   <= 1'b0;
      lat_rnw     <= 1'b0;
      lat_apndp   <= 1'b0;
      lat_addr32  <= '0;
      lat_wdata   <= '0;
      resp_ack    <= '0;
      resp_rdata  <= '0;
      jtag_cmd    <= '0;
      jtag_addr32 <= '0;
      jtag_rnw    <= 1'b0;
      jtag_apndp  <= 1'b0;
      jtag_dwrite <= '0;
      jtag_go     <= 1'b0;
    end else begin
      state      <= state_d;
      kind       <= kind_d;
      ir         <= ir_d;
      retry      <= retry_d;
      req_ready  <= (state_d == S_IDLE);
      resp_ack   <= ack_d;
      resp_rdata <= rdata_d;
      if (accept) begin
        lat_rnw    <= req_rnw;
        lat_apndp  <= req_apndp;
        lat_addr32 <= req_addr32;
        lat_wdata  <= req_wdata;
      end
      if (launch) begin
        jtag_cmd    <= go_cmd;
        jtag_addr32 <= go_addr32;
        jtag_rnw    <= go_rnw;
        jtag_apndp  <= go_apndp;
        jtag_dwrite <= go_dwrite;
        jtag_go     <= 1'b1;
      end else if (state == S_LAUNCH && !jtag_idle) begin
        jtag_go <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jtag_xfer_ctrl.md
Name: jtag_xfer_ctrl

Overview:
Transfer sequencer sitting directly upstream of the JTAG pin engine (jtagIF) and below the CMSIS-DAP command processor. Accepts one DP/AP register transfer at a time, selects the right IR (DPACC/APACC) only when it changes, drives the engine's cmd/go/idle handshake, retries on WAIT, and flushes posted AP reads through DP RDBUFF. Returns a single host-format response per request. Also sequences TAP abort/reset on request.

Parameters:
RETRY_MAX, 16, WAIT retries per engine transfer before the host response is WAIT (0 = no retry).
RDBUFF_ADDR, 2'b11, addr32 value of DP RDBUFF (0x0C).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  host transfer request
req_ready  out  1  high when a request can be accepted
req_abort  in  1  abort/TAP reset request; sampled only when req_ready is high; has priority over req_valid
req_rnw  in  1  1 = read
req_apndp  in  1  1 = AP, 0 = DP
req_addr32  in  2  register address bits 3:2
req_wdata  in  32  write data
resp_valid  out  1  one-cycle response strobe
resp_ack  out  3  3'b001 OK, 3'b010 WAIT, 3'b100 FAULT, 3'b111 protocol error
resp_rdata  out  32  read data; valid with resp_valid on OK reads, else 0
jtag_cmd  out  2  engine command (0 IR, 1 TFR, 2 ABORT, 3 READID)
jtag_addr32  out  2  to engine
jtag_rnw  out  1  to engine
jtag_apndp  out  1  to engine; during IR command selects APACC (1) or DPACC (0)
jtag_dwrite  out  32  to engine
jtag_go  out  1  engine trigger
jtag_idle  in  1  engine idle
jtag_ack  in  3  engine ack (3'b010 OK/FAULT, 3'b001 WAIT)
jtag_dread  in  32  engine read data

Behaviour:
- Reset: req_ready=0 until the first clk after release, then 1; resp_valid=0, resp_ack=0, resp_rdata=0, jtag_go=0, all jtag_* data outputs 0; cached IR = UNKNOWN; retry count=0; state IDLE.
- States: IDLE, LAUNCH, BUSY, EVAL, RESP. A "step" = LAUNCH->BUSY->EVAL with a step kind (SETIR, XFER, RDBUFF, ABORT).
- IDLE: req_ready=1. Abort has priority: latch, step ABORT (jtag_cmd=2). Else req_valid: latch all req_* fields into holding regs, req_ready=0 next cycle; first step = SETIR if cached IR != req_apndp (or UNKNOWN), else XFER.
- LAUNCH: jtag_go=1 with jtag_* held stable; stay until jtag_idle==0 observed, then jtag_go<=0, go BUSY. Engine idle is gated by its rising strobe; no cycle bound assumed.
- BUSY: wait for jtag_idle==1, then EVAL next cycle (jtag_ack/jtag_dread sampled in EVAL).
- SETIR done: cached IR <= latched apndp; next XFER. IR step ack not checked.
- XFER: jtag_cmd=1, jtag_addr32/rnw/apndp/dwrite from latch.
  - ack 001 (WAIT): if retry<RETRY_MAX, retry++ and relaunch same step; else respond WAIT.
  - ack 010: retry<=0. AP read -> step RDBUFF (jtag_cmd=1, apndp=0, rnw=1, addr32=RDBUFF_ADDR; IR switched to DPACC first via SETIR, cache updated). DP read/any write -> respond OK with jtag_dread (reads) or 0.
  - other ack -> respond protocol error, cached IR <= UNKNOWN.
- RDBUFF: same WAIT retry rules (counter restarted); 010 -> respond OK with its jtag_dread.
- FAULT: reported only when the command processor later reads CTRL/STAT; this block never produces 3'b100 on its own except when jtag_ack==3'b100 (passed through, cached IR unchanged).
- ABORT done: cached IR <= UNKNOWN, retry<=0, respond OK, rdata 0.
- RESP: resp_valid=1 exactly one cycle, resp_ack/resp_rdata held until next response; return IDLE (req_ready=1 next cycle). Back-to-back requests: minimum 1 idle cycle between resp_valid and next acceptance.
- req_valid/req_abort ignored while req_ready=0. Asynchronous reset mid-transfer drops jtag_go immediately and discards the pending request (no response).

Test Plan:
- DP write addr 1, wdata 0x5000_0000, cached IR UNKNOWN -> engine sees IR(apndp 0) then TFR; one resp_valid with ack 3'b001, rdata 0.
- Two consecutive DP reads addr 0, engine returns 0x2BA0_1477 -> only first request issues IR; both respond OK, rdata 0x2BA0_1477.
- AP read addr 3, engine returns 0xDEAD on TFR and 0x2477_0011 on RDBUFF -> sequence IR(AP), TFR, IR(DP), TFR addr 3; resp OK rdata 0x2477_0011.
- RETRY_MAX=2, engine ack 001 three times -> exactly 3 TFR launches, resp ack 3'b010; next request with ack 010 on first try -> 1 launch, OK.
- Engine ack 3'b111 -> resp 3'b111; following request reissues IR.
- req_abort and req_valid together in IDLE -> ABORT command issued, resp OK, next request reissues IR; rst low during BUSY -> jtag_go=0, no resp_valid.
